vga_pixel_feeder: RTL and testbench
===================================

// Module: vga_pixel_feeder
// PURPOSE
// Pixel-clock stage feeding the VGA output. Pulls 32-bit framebuffer words from the read port
// of the pixel FIFO (written by the Wishbone framebuffer reader). Aligns them with the
// HS/VS/DE timing from the VGA timing generator. Emits the final aligned RGB + sync.
// Starts streaming only once the FIFO is full and a frame boundary is seen. Detects underflow
// and frame-length errors and requests an upstream restart.
// PARAMETERS
// HDISP      800  active pixels per line
// VDISP      480  active lines per frame
// CNT_W      16   width of underflow_cnt
// PORTS
// pixel_clk    in   1      pixel clock
// pixel_rst    in   1      reset, asynchronous, active-high
// in_hs        in   1      line sync from timing generator, active-low
// in_vs        in   1      frame sync from timing generator, active-low
// in_de        in   1      1 = active display pixel this cycle
// fifo_rdata   in   32     FIFO read data, valid 1 cycle after fifo_rd
// fifo_rempty  in   1      FIFO empty, pixel_clk domain
// fifo_full_s  in   1      FIFO write-full, already synchronised to pixel_clk
// fifo_rd      out  1      FIFO read enable
// out_hs       out  1      aligned line sync, active-low
// out_vs       out  1      aligned frame sync, active-low
// out_de       out  1      aligned display enable
// out_rgb      out  24     aligned pixel {R,G,B} = fifo_rdata[23:0]
// restart_req  out  1      1-cycle pulse: upstream flushes FIFO, restarts at address 0
// underflow_cnt out CNT_W  saturating count of error events
// BEHAVIOUR
// Reset values
// - out_hs=1, out_vs=1, out_de=0, out_rgb=0, fifo_rd=0, restart_req=0, underflow_cnt=0.
// - Frame pixel counter = 0; state = WAIT_FULL.
// frame_start
// - 1-cycle event on in_vs falling edge (registered previous in_vs = 1, current = 0).
// - Previous in_vs resets to 1.
// States
// - WAIT_FULL: fifo_rd=0. Go to WAIT_FRAME when fifo_full_s=1.
// - WAIT_FRAME: fifo_rd=0. Go to STREAM on frame_start. Pixel counter cleared.
// - STREAM: fifo_rd = in_de & ~fifo_rempty (combinational).
//   - in_de=1 & fifo_rempty=1 -> underflow; go to RESYNC.
//   - On frame_start, pixel counter != HDISP*VDISP -> error; go to RESYNC.
//   - Otherwise clear the counter and stay in STREAM.
//   - Counter increments on each fifo_rd and saturates at HDISP*VDISP.
// - RESYNC: restart_req=1 for this single cycle; underflow_cnt += 1 (saturating at all-ones).
//   Go to WAIT_FULL.
// - Underflow and frame_start in the same cycle: underflow takes priority; one increment only.
// Pipeline
// - Fixed latency 2 pixel_clk from in_* to out_*.
// - Stage 1 registers in_hs/vs/de and rd_q = fifo_rd.
// - Stage 2 registers out_hs/vs/de.
// - Stage 2: out_rgb = rd_q ? fifo_rdata[23:0] : 24'h0.
// - fifo_rdata[31:24] ignored.
// - Outside STREAM: out_rgb = 0 while out_de still follows delayed in_de (black screen,
//   valid timing).
// - Pixel-count target: HDISP*VDISP, computed at elaboration, width $clog2(HDISP*VDISP+1).
// - Reset mid-frame: all of the above return to reset values immediately.
//   Sync outputs resume 2 cycles after reset release.
// TESTING
// Bench parameters: HDISP=8, VDISP=4, timing-generator model with 4-cycle porches/pulses.
// - Reset, fifo_full_s=0 for 3 frames -> fifo_rd never 1; out_rgb=0; out_hs/out_vs = inputs
//   delayed by 2.
// - FIFO preloaded with 0x00000000..0x0000001F, fifo_full_s=1, then frame -> first out_de
//   pixel = 24'h000000 after frame_start.
//   - 32 pixels ascending in order; no restart_req.
// - Sustained 3 frames with a never-empty FIFO -> 96 reads, underflow_cnt=0.
//   Every out_de=1 cycle carries data; out_de=0 cycles carry 0.
// - fifo_rempty forced 1 at pixel 10 of frame 2 -> exactly one restart_req pulse; underflow_cnt=1.
//   - State returns to WAIT_FULL; next streaming begins only after full + frame_start.
// - FIFO data with bits [31:24]=0xAB -> out_rgb ignores them (e.g. 0xAB123456 -> 24'h123456).
// - pixel_rst pulsed mid-line during STREAM -> all outputs at reset values the same cycle;
//   restart_req=0.
//   - underflow_cnt=0; streaming resumes only after fifo_full_s and a new frame_start.

Source files
------------

// File: rtl/vga_pixel_feeder.sv
// Pixel-clock feeder: pulls framebuffer words from the pixel FIFO and aligns them with the VGA timing.
// Streams only after FIFO-full plus a frame boundary; underflow or bad frame length triggers an upstream restart.
`timescale 1ns/1ps
module vga_pixel_feeder #(
    parameter int unsigned HDISP = 800,
    parameter int unsigned VDISP = 480,
    parameter int unsigned CNT_W = 16
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic             in_hs,
    input  logic             in_vs,
    input  logic             in_de,
    input  logic [31:0]      fifo_rdata,
    input  logic             fifo_rempty,
    input  logic             fifo_full_s,
    output logic             fifo_rd,
    output logic             out_hs,
    output logic             out_vs,
    output logic             out_de,
    output logic [23:0]      out_rgb,
    output logic             restart_req,
    output logic [CNT_W-1:0] underflow_cnt
);
    localparam int unsigned      PIX_TOTAL  = HDISP * VDISP;
    localparam int unsigned      PIX_W      = $clog2(PIX_TOTAL + 1);
    localparam logic [PIX_W-1:0] PIX_TARGET = PIX_W'(PIX_TOTAL);

    typedef enum logic [1:0] {
        WAIT_FULL,
        WAIT_FRAME,
        STREAM,
        RESYNC
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] w_pix_cnt_nxt;
    logic             r_vs_prev;
    logic             w_frame_start;
    logic             r_hs1;
    logic             r_vs1;
    logic             r_de1;
    logic             r_rd_q;
    logic             w_unused_rdata_hi;

    assign w_frame_start     = r_vs_prev & ~in_vs;
    assign w_unused_rdata_hi = ^fifo_rdata[31:24];

    always_comb begin
        w_state_nxt   = r_state;
        w_pix_cnt_nxt = r_pix_cnt;
        fifo_rd       = 1'b0;
        restart_req   = 1'b0;
        case (r_state)
            WAIT_FULL: begin
                if (fifo_full_s) w_state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                w_pix_cnt_nxt = '0;
                if (w_frame_start) w_state_nxt = STREAM;
            end
            STREAM: begin
                fifo_rd = in_de & ~fifo_rempty;
                // Underflow outranks a coincident frame boundary so only one error is logged.
                if (in_de && fifo_rempty) begin
                    w_state_nxt = RESYNC;
                end else if (w_frame_start) begin
                    if (r_pix_cnt != PIX_TARGET) w_state_nxt = RESYNC;
                    else                         w_pix_cnt_nxt = '0;
                end else if (fifo_rd && (r_pix_cnt != PIX_TARGET)) begin
                    w_pix_cnt_nxt = r_pix_cnt + PIX_W'(1);
                end
            end
            RESYNC: begin
                restart_req = 1'b1;
                w_state_nxt = WAIT_FULL;
            end
            default: w_state_nxt = WAIT_FULL;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state       <= WAIT_FULL;
            r_pix_cnt     <= '0;
            r_vs_prev     <= 1'b1;
            underflow_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= w_pix_cnt_nxt;
            r_vs_prev <= in_vs;
            if ((r_state == RESYNC) && (underflow_cnt != '1))
                underflow_cnt <= underflow_cnt + CNT_W'(1);
        end
    end

    // Two-stage alignment: the FIFO word arrives one cycle after fifo_rd, so it joins at stage 2.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hs1   <= 1'b1;
            r_vs1   <= 1'b1;
            r_de1   <= 1'b0;
            r_rd_q  <= 1'b0;
            out_hs  <= 1'b1;
            out_vs  <= 1'b1;
            out_de  <= 1'b0;
            out_rgb <= '0;
        end else begin
            r_hs1   <= in_hs;
            r_vs1   <= in_vs;
            r_de1   <= in_de;
            r_rd_q  <= fifo_rd;
            out_hs  <= r_hs1;
            out_vs  <= r_vs1;
            out_de  <= r_de1;
            out_rgb <= r_rd_q ? fifo_rdata[23:0] : '0;
        end
    end

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: 8x4 frame, 4-cycle porches/pulses, 32-deep FIFO model.
`timescale 1ns/1ps
module tb_vga_pixel_feeder;
    localparam int unsigned DEPTH = 32;

    logic        pixel_clk;
    logic        pixel_rst;
    logic        in_hs;
    logic        in_vs;
    logic        in_de;
    logic [31:0] fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_full_s;
    logic        fifo_rd;
    logic        out_hs;
    logic        out_vs;
    logic        out_de;
    logic [23:0] out_rgb;
    logic        restart_req;
    logic [15:0] underflow_cnt;

    vga_pixel_feeder #(.HDISP(8), .VDISP(4), .CNT_W(16)) dut (
        .pixel_clk    (pixel_clk),
        .pixel_rst    (pixel_rst),
        .in_hs        (in_hs),
        .in_vs        (in_vs),
        .in_de        (in_de),
        .fifo_rdata   (fifo_rdata),
        .fifo_rempty  (fifo_rempty),
        .fifo_full_s  (fifo_full_s),
        .fifo_rd      (fifo_rd),
        .out_hs       (out_hs),
        .out_vs       (out_vs),
        .out_de       (out_de),
        .out_rgb      (out_rgb),
        .restart_req  (restart_req),
        .underflow_cnt(underflow_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    int unsigned n_cmp, n_bad;
    int unsigned h, v, wr_n, de_idx, fs_cnt, rd_cnt, restart_cnt;
    int unsigned sync_err, blank_err, rgb_nz, holdoff, data_err;
    int          force_at;
    bit          refill, collect, rdata_valid, vs_last, ok;
    logic [31:0] rdata_word;
    logic [2:0]  prev_in;
    logic [31:0] fq[$];
    logic [23:0] seen[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel clock: drive timing + FIFO model, then sample outputs 1ns after the edge.
    task automatic cycle();
        in_hs = !(h >= 12 && h < 16);
        in_vs = !(v >= 8 && v < 12);
        in_de = (v < 4) && (h < 8);
        if (vs_last && !in_vs) begin
            fs_cnt++;
            de_idx = 0;
        end
        vs_last     = in_vs;
        fifo_rdata  = rdata_valid ? rdata_word : 32'hFF5A5A5A;
        fifo_full_s = (fq.size() >= DEPTH);
        fifo_rempty = (fq.size() == 0);
        if (force_at >= 0 && in_de && de_idx == force_at) begin
            fifo_rempty = 1'b1;
            force_at    = -1;
        end
        if (in_de) de_idx++;
        #1;
        rdata_valid = 1'b0;
        if (fifo_rd === 1'b1) begin
            rd_cnt++;
            collect = 1'b1;
            if (fq.size() > 0) begin
                rdata_word  = fq.pop_front();
                rdata_valid = 1'b1;
            end
        end
        if (refill && fq.size() < DEPTH) begin
            fq.push_back(32'hAB000000 | (32'h00123456 + wr_n));
            wr_n++;
        end
        @(posedge pixel_clk);
        #1;
        if (restart_req === 1'b1) begin
            restart_cnt++;
            fq.delete();
            wr_n = 0;
        end
        if (out_rgb !== 24'h0) rgb_nz++;
        if (out_de === 1'b1) begin
            if (collect) seen.push_back(out_rgb);
        end else if (out_rgb !== 24'h0) begin
            blank_err++;
        end
        if (!pixel_rst) begin
            if (holdoff > 0) holdoff--;
            else if ({out_hs, out_vs, out_de} !== prev_in) sync_err++;
        end
        prev_in = {in_hs, in_vs, in_de};
        h++;
        if (h == 20) begin
            h = 0;
            v = (v + 1) % 16;
        end
    endtask

    // kind 0: next fifo_rd, 1: next frame start, 2: next restart pulse
    task automatic wait_for(input int kind, input int unsigned lim, output bit hit);
        int unsigned r0, f0, s0;
        r0 = rd_cnt; f0 = fs_cnt; s0 = restart_cnt;
        hit = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            cycle();
            if ((kind == 0 && rd_cnt != r0) || (kind == 1 && fs_cnt != f0) ||
                (kind == 2 && restart_cnt != s0)) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        pixel_rst = 1'b1;
        cycle();
        cycle();
        pixel_rst   = 1'b0;
        holdoff     = 1;
        fq.delete();
        rdata_valid = 1'b0;
        wr_n        = 0;
        seen.delete();
        collect     = 1'b0;
    endtask

    function automatic logic [23:0] first_seen();
        return (seen.size() > 0) ? seen[0] : 24'hxxxxxx;
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0;
        h = 0; v = 4; wr_n = 0; de_idx = 0; fs_cnt = 0; rd_cnt = 0; restart_cnt = 0;
        sync_err = 0; blank_err = 0; rgb_nz = 0; holdoff = 0; data_err = 0;
        force_at = -1; refill = 0; collect = 0; rdata_valid = 0; vs_last = 1;
        rdata_word = '0; prev_in = 3'b110;

        pixel_rst = 1'b1;
        cycle();
        cycle();
        check("rst_out_hs", 32'(out_hs), 32'd1);
        check("rst_out_vs", 32'(out_vs), 32'd1);
        check("rst_out_de", 32'(out_de), 32'd0);
        check("rst_out_rgb", 32'(out_rgb), 32'd0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_restart", 32'(restart_req), 32'd0);
        check("rst_ucnt", 32'(underflow_cnt), 32'd0);
        pixel_rst = 1'b0;
        holdoff   = 1;

        // Never full for 3 frames: black screen, timing passes through.
        rd_cnt = 0; rgb_nz = 0; sync_err = 0;
        repeat (960) cycle();
        check("nofull_rd", rd_cnt, 0);
        check("nofull_rgb", rgb_nz, 0);
        check("nofull_sync", sync_err, 0);

        // Preloaded 0..31, full, one frame.
        restart_cnt = 0; seen.delete(); collect = 0;
        for (int unsigned i = 0; i < 32; i++) fq.push_back(32'(i));
        for (int unsigned i = 0; i < 1200 && seen.size() < 32; i++) cycle();
        check("pre_len", seen.size(), 32);
        check("pre_first", 32'(first_seen()), 32'h0);
        data_err = 0;
        foreach (seen[i]) if (seen[i] !== 24'(i)) data_err++;
        check("pre_order", data_err, 0);
        check("pre_restart", restart_cnt, 0);

        // Sustained 3 frames with a never-empty FIFO; top byte 0xAB must be dropped.
        do_reset();
        refill = 1; restart_cnt = 0; rd_cnt = 0;
        wait_for(0, 1000, ok);
        check("sus_start", 32'(ok), 32'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            wait_for(1, 400, ok);
            check("sus_frame", 32'(ok), 32'd1);
        end
        cycle();
        cycle();
        check("sus_reads", rd_cnt, 96);
        check("sus_pixels", seen.size(), 96);
        check("sus_first", 32'(first_seen()), 32'h123456);
        data_err = 0;
        foreach (seen[i]) if (seen[i] !== 24'(32'h123456 + i)) data_err++;
        check("sus_data", data_err, 0);
        check("sus_ucnt", 32'(underflow_cnt), 32'd0);
        check("sus_restart", restart_cnt, 0);
        check("blank_rgb", blank_err, 0);

        // Underflow at pixel 10 of streamed frame 2.
        do_reset();
        restart_cnt = 0;
        wait_for(0, 1000, ok);
        wait_for(1, 400, ok);
        force_at = 10;
        wait_for(2, 400, ok);
        check("uf_pulse_seen", 32'(ok), 32'd1);
        rd_cnt = 0;
        wait_for(1, 400, ok);
        check("uf_idle_rd", rd_cnt, 0);
        seen.delete(); collect = 0;
        wait_for(0, 400, ok);
        check("uf_resume", 32'(ok), 32'd1);
        cycle();
        cycle();
        cycle();
        check("uf_resume_pix", 32'(first_seen()), 32'h123456);
        check("uf_pulses", restart_cnt, 1);
        check("uf_ucnt", 32'(underflow_cnt), 32'd1);

        // Reset mid-line while streaming.
        for (int unsigned i = 0; i < 400 && !(in_de && h == 5); i++) cycle();
        check("mid_out_de_pre", 32'(out_de), 32'd1);
        pixel_rst = 1'b1;
        #1;
        check("mid_out_hs", 32'(out_hs), 32'd1);
        check("mid_out_vs", 32'(out_vs), 32'd1);
        check("mid_out_de", 32'(out_de), 32'd0);
        check("mid_out_rgb", 32'(out_rgb), 32'd0);
        check("mid_fifo_rd", 32'(fifo_rd), 32'd0);
        check("mid_restart", 32'(restart_req), 32'd0);
        check("mid_ucnt", 32'(underflow_cnt), 32'd0);
        do_reset();
        rd_cnt = 0;
        wait_for(1, 700, ok);
        check("mid_idle_rd", rd_cnt, 0);
        wait_for(0, 400, ok);
        check("mid_resume", 32'(ok), 32'd1);
        repeat (3) cycle();
        check("mid_resume_pix", 32'(first_seen()), 32'h123456);
        check("sync_delay2", sync_err, 0);
        check("blank_rgb_all", blank_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
